// File: rtl/resource_grant_sched_pkg.sv
// Shared types for the round-robin resource grant scheduler.
package resource_grant_sched_pkg;

    typedef enum logic {
        SCHED_IDLE,
        SCHED_GRANTED
    } sched_state_t;

endpackage

// File: rtl/idx_to_oh.sv
// Binary index to one-hot decoder, bit 0 of the output corresponds to index 0.
module idx_to_oh #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [IDX_WIDTH-1:0] idx,
    output logic [WIDTH-1:0]     oh
);

    always_comb begin
        oh = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            oh[i] = (32'(idx) == i);
        end
    end

endmodule

// File: rtl/resource_grant_sched.sv
// Round-robin grant scheduler with a hold limit that forces rotation under contention.
// All outputs are registered; the grant is presented as both index and one-hot vector.
module resource_grant_sched
    import resource_grant_sched_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned MAX_HOLD       = 8,
    parameter int unsigned INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] request,
    output logic                      grant_valid,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0]    grant_idx
);

    localparam int unsigned HOLD_WIDTH = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(MAX_HOLD - 1);

    sched_state_t              state_q, state_d;
    logic [INDEX_WIDTH-1:0]    idx_q, idx_d;
    logic [NUM_REQUESTERS-1:0] oh_q, oh_d;
    logic [INDEX_WIDTH-1:0]    last_q, last_d;
    logic [HOLD_WIDTH-1:0]     hold_q, hold_d;

    logic [NUM_REQUESTERS-1:0] cand;
    logic [INDEX_WIDTH-1:0]    rr_pos;
    logic                      win_found;
    logic [INDEX_WIDTH-1:0]    win_idx;
    logic [NUM_REQUESTERS-1:0] win_oh;
    logic                      take;

    // Owner is masked out so a rearbitration never re-picks the current holder;
    // oh_q is zero while idle, so the same mask is harmless there.
    always_comb begin
        cand      = request & ~oh_q;
        rr_pos    = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            rr_pos = INDEX_WIDTH'((32'(last_q) + 32'd1 + i) % NUM_REQUESTERS);
            if (!win_found && cand[rr_pos]) begin
                win_found = 1'b1;
                win_idx   = rr_pos;
            end
        end
    end

    idx_to_oh #(
        .WIDTH     (NUM_REQUESTERS),
        .IDX_WIDTH (INDEX_WIDTH)
    ) u_idx_to_oh (
        .idx (win_idx),
        .oh  (win_oh)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        last_d  = last_q;
        hold_d  = hold_q;
        take    = 1'b0;

        unique case (state_q)
            SCHED_IDLE: begin
                take = win_found;
            end
            SCHED_GRANTED: begin
                if (!request[idx_q]) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = SCHED_IDLE;
                        oh_d    = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX) begin
                    take = win_found;
                end else begin
                    hold_d = hold_q + HOLD_WIDTH'(1);
                end
            end
            default: begin
                state_d = SCHED_IDLE;
            end
        endcase

        if (take) begin
            state_d = SCHED_GRANTED;
            idx_d   = win_idx;
            oh_d    = win_oh;
            last_d  = win_idx;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCHED_IDLE;
            idx_q   <= '0;
            oh_q    <= '0;
            last_q  <= INDEX_WIDTH'(NUM_REQUESTERS - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign grant_valid = (state_q == SCHED_GRANTED);
    assign grant_oh    = oh_q;
    assign grant_idx   = idx_q;

endmodule
